// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and pipeline latency for scaled_sprite_renderer (SPRITE_MIRROR_EN adds a flip control).
package sprite_pkg;
    localparam int SPRITE_LATENCY = 5;
    typedef logic [1:0] scale_t;
    typedef logic [10:0] hcount_t;
    typedef logic [9:0] vcount_t;
    typedef struct packed {
        hcount_t x;
        vcount_t y;
        scale_t  scale;
        logic    enable;
`ifdef SPRITE_MIRROR_EN
        logic    flip;
`endif
    } ctrl_t;
endpackage

// File: rtl/sprite_delay_line.sv
// sprite_delay_line: fixed-depth shift register with asynchronous clear.
module sprite_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// xilinx_single_port_ram_read_first: single-port block RAM, read-first, optional output register.
module xilinx_single_port_ram_read_first #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string INIT_FILE       = ""
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);
    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] data_q;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem_q[addra] <= dina;
            data_q <= mem_q[addra];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low
        assign douta = data_q;
    end else begin : g_high
        always_ff @(posedge clka or posedge rsta) begin
            if (rsta) douta <= '0;
            else if (regcea) douta <= data_q;
        end
    end
endmodule

// File: rtl/scaled_sprite_renderer.sv
// scaled_sprite_renderer: ROM-backed palettised sprite with power-of-two scale and colour key, 5-cycle aligned output.
// Defining SPRITE_MIRROR_EN adds flip_h_in for horizontal mirroring.
module scaled_sprite_renderer
    import sprite_pkg::*;
#(
    parameter int    WIDTH             = 128,
    parameter int    HEIGHT            = 128,
    parameter int    INDEX_BITS        = 8,
    parameter int    COLOR_BITS        = 12,
    parameter int    TRANSPARENT_INDEX = 0,
    parameter string IMAGE_FILE        = "image.mem",
    parameter string PALETTE_FILE      = "palette.mem"
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    input  hcount_t               x_in,
    input  vcount_t               y_in,
    input  scale_t                scale_in,
    input  logic                  enable_in,
`ifdef SPRITE_MIRROR_EN
    input  logic                  flip_h_in,
`endif
    input  hcount_t               hcount_in,
    input  vcount_t               vcount_in,
    output logic [COLOR_BITS-1:0] pixel_out,
    output logic                  pixel_valid_out,
    output hcount_t               hcount_out,
    output vcount_t               vcount_out
);
    localparam int AW = $clog2(WIDTH * HEIGHT);

    ctrl_t                 ctrl_q, ctrl_d;
    logic                  frame_start;
    logic [12:0]           dx, dy, col, row;
    logic [13:0]           ext_w, ext_h;
    logic                  in_sprite_d, in_sprite_q, in_sprite_dl;
    logic [AW-1:0]         addr_d, addr_q;
    logic [INDEX_BITS-1:0] index, index_dl;
    logic [COLOR_BITS-1:0] color;
    logic [20:0]           hv_dl;

    // Offsets are 13-bit signed and extents 14-bit so an overhanging sprite never wraps.
    always_comb begin
        frame_start = (hcount_in == '0) && (vcount_in == '0);
        ctrl_d.x = frame_start ? x_in : ctrl_q.x;
        ctrl_d.y = frame_start ? y_in : ctrl_q.y;
        ctrl_d.scale = frame_start ? scale_in : ctrl_q.scale;
        ctrl_d.enable = frame_start ? enable_in : ctrl_q.enable;
`ifdef SPRITE_MIRROR_EN
        ctrl_d.flip = frame_start ? flip_h_in : ctrl_q.flip;
`endif
        dx = 13'(hcount_in) - 13'(ctrl_q.x);
        dy = 13'(vcount_in) - 13'(ctrl_q.y);
        ext_w = 14'(WIDTH) << ctrl_q.scale;
        ext_h = 14'(HEIGHT) << ctrl_q.scale;
        in_sprite_d = ctrl_q.enable && !dx[12] && (14'(dx) < ext_w) && !dy[12] && (14'(dy) < ext_h);
`ifdef SPRITE_MIRROR_EN
        col = ctrl_q.flip ? 13'(WIDTH - 1) - (dx >> ctrl_q.scale) : dx >> ctrl_q.scale;
`else
        col = dx >> ctrl_q.scale;
`endif
        row = dy >> ctrl_q.scale;
        addr_d = in_sprite_d ? AW'(32'(row) * 32'(WIDTH) + 32'(col)) : '0;
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            ctrl_q <= '0;
            in_sprite_q <= 1'b0;
            addr_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            in_sprite_q <= in_sprite_d;
            addr_q <= addr_d;
        end
    end

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH(INDEX_BITS), .RAM_DEPTH(WIDTH * HEIGHT),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE(IMAGE_FILE)
    ) u_img_rom (
        .addra(addr_q), .dina('0), .clka(pixel_clk_in), .wea(1'b0), .ena(1'b1),
        .rsta(rst_in), .regcea(1'b1), .douta(index)
    );

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH(COLOR_BITS), .RAM_DEPTH(2 ** INDEX_BITS),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE(PALETTE_FILE)
    ) u_pal_rom (
        .addra(index), .dina('0), .clka(pixel_clk_in), .wea(1'b0), .ena(1'b1),
        .rsta(rst_in), .regcea(1'b1), .douta(color)
    );

    // The flag covers both ROMs after S1; the index waits out the palette read.
    sprite_delay_line #(.WIDTH(1), .DEPTH(SPRITE_LATENCY - 1)) u_valid_dl (
        .clk_i(pixel_clk_in), .rst_i(rst_in), .d_i(in_sprite_q), .q_o(in_sprite_dl)
    );

    sprite_delay_line #(.WIDTH(INDEX_BITS), .DEPTH(2)) u_index_dl (
        .clk_i(pixel_clk_in), .rst_i(rst_in), .d_i(index), .q_o(index_dl)
    );

    sprite_delay_line #(.WIDTH(21), .DEPTH(SPRITE_LATENCY)) u_hv_dl (
        .clk_i(pixel_clk_in), .rst_i(rst_in), .d_i({hcount_in, vcount_in}), .q_o(hv_dl)
    );

    always_comb begin
        pixel_valid_out = in_sprite_dl && (index_dl != INDEX_BITS'(TRANSPARENT_INDEX));
        pixel_out = pixel_valid_out ? color : '0;
        hcount_out = hv_dl[20:10];
        vcount_out = hv_dl[9:0];
    end
endmodule

// File: tb/tb_scaled_sprite_renderer.sv
// tb_scaled_sprite_renderer: randomized scoreboard bench against a geometric sprite model.
module tb_scaled_sprite_renderer;
    import sprite_pkg::*;

    localparam int W = 8;
    localparam int H = 8;

    typedef struct packed {
        logic [11:0] pix;
        logic        valid;
        hcount_t     h;
        vcount_t     v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    hcount_t     x_in = '0;
    vcount_t     y_in = '0;
    scale_t      scale_in = '0;
    logic        enable_in = 1'b0;
    hcount_t     hcount_in = '0;
    vcount_t     vcount_in = '0;
    logic [11:0] pixel_out;
    logic        pixel_valid_out;
    hcount_t     hcount_out;
    vcount_t     vcount_out;
`ifdef SPRITE_MIRROR_EN
    logic        flip_h_in = 1'b0;
`endif

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  img[W*H];
    logic [11:0] pal[256];
    int          nx, ny, nsc;
    bit          nen, nfl;
    int          sx, sy, ssc;
    bit          sen, sfl;

    scaled_sprite_renderer #(
        .WIDTH(W), .HEIGHT(H), .INDEX_BITS(8), .COLOR_BITS(12), .TRANSPARENT_INDEX(0),
        .IMAGE_FILE(""), .PALETTE_FILE("")
    ) dut (
        .pixel_clk_in(clk), .rst_in(rst), .x_in(x_in), .y_in(y_in), .scale_in(scale_in),
        .enable_in(enable_in),
`ifdef SPRITE_MIRROR_EN
        .flip_h_in(flip_h_in),
`endif
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_out(pixel_out),
        .pixel_valid_out(pixel_valid_out), .hcount_out(hcount_out), .vcount_out(vcount_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int h, int v);
        exp_t e;
        int ew, eh, col, row, idx;
        e = '0;
        e.h = hcount_t'(h);
        e.v = vcount_t'(v);
        ew = W << ssc;
        eh = H << ssc;
        if (sen && h >= sx && h < sx + ew && v >= sy && v < sy + eh) begin
            col = (h - sx) >> ssc;
            row = (v - sy) >> ssc;
            if (sfl) col = W - 1 - col;
            idx = int'(img[row * W + col]);
            if (idx != 0) begin
                e.valid = 1'b1;
                e.pix = pal[idx];
            end
        end
        return e;
    endfunction

    task automatic cyc(input int h, input int v);
        @(posedge clk);
        #1;
        rst = 1'b0;
        x_in = hcount_t'(nx);
        y_in = vcount_t'(ny);
        scale_in = scale_t'(nsc);
        enable_in = nen;
`ifdef SPRITE_MIRROR_EN
        flip_h_in = nfl;
`endif
        hcount_in = hcount_t'(h);
        vcount_in = vcount_t'(v);
        q.push_back(model(h, v));
        if (h == 0 && v == 0) begin
            sx = nx; sy = ny; ssc = nsc; sen = nen;
`ifdef SPRITE_MIRROR_EN
            sfl = nfl;
`else
            sfl = 1'b0;
`endif
        end
    endtask

    task automatic span(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) cyc(h, v);
    endtask

    task automatic frame(input int x, input int y, input int sc, input bit en, input bit fl);
        nx = x; ny = y; nsc = sc; nen = en; nfl = fl;
        cyc(0, 0);
    endtask

    task automatic pipeline_reset();
        q.delete();
        for (int i = 0; i < SPRITE_LATENCY; i++) q.push_back('0);
        sx = 0; sy = 0; ssc = 0; sen = 1'b0; sfl = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        pipeline_reset();
        repeat (2) @(posedge clk);
    endtask

    // mode 0: ramp, 1: ramp with transparent addr 0, 2: random with ~25% transparent
    task automatic load(input int mode);
        nen = 1'b0;
        cyc(0, 0);
        repeat (6) cyc(1, 0);
        for (int a = 0; a < W * H; a++) begin
            img[a] = (mode == 2) ? (($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom)) : 8'(a + 1);
            if (mode == 1 && a == 0) img[a] = 8'd0;
            dut.u_img_rom.mem_q[a] = img[a];
        end
        for (int i = 0; i < 256; i++) begin
            pal[i] = (mode == 2) ? 12'($urandom) : 12'(i);
            dut.u_pal_rom.mem_q[i] = pal[i];
        end
    endtask

    always @(negedge clk) begin
        exp_t a, e;
        a = {pixel_out, pixel_valid_out, hcount_out, vcount_out};
        if (rst) begin
            checks++;
            if (a !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got pix=%h valid=%b h=%0d v=%0d, need all 0",
                         pixel_out, pixel_valid_out, hcount_out, vcount_out);
            end
        end else if (q.size() > SPRITE_LATENCY) begin
            e = q.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL pixel h=%0d v=%0d: got pix=%h valid=%b h=%0d v=%0d, need pix=%h valid=%b h=%0d v=%0d",
                         e.h, e.v, a.pix, a.valid, a.h, a.v, e.pix, e.valid, e.h, e.v);
            end
        end
    end

    initial begin
        int x, y, sc, ext, h, v;
        nx = 0; ny = 0; nsc = 0; nen = 1'b0; nfl = 1'b0;
        pipeline_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        nx = 100; ny = 50; nen = 1'b1;
        span(50, 98, 110);
        load(0);
        frame(100, 50, 0, 1'b1, 1'b0);
        for (int r = 49; r <= 58; r++) span(r, 95, 110);
        frame(100, 50, 2, 1'b1, 1'b0);
        span(49, 97, 134); span(50, 97, 134); span(54, 97, 134); span(81, 97, 134); span(82, 97, 134);
        load(1);
        frame(100, 50, 0, 1'b1, 1'b0);
        span(50, 98, 103);
        load(0);
        frame(100, 50, 0, 1'b1, 1'b0);
        span(50, 98, 110);
        nx = 300;
        span(51, 98, 110); span(51, 298, 310);
        frame(300, 50, 0, 1'b1, 1'b0);
        span(50, 98, 110); span(50, 298, 310);
        frame(2040, 50, 0, 1'b1, 1'b0);
        span(50, 2036, 2047); span(50, 1, 10); span(51, 0, 10);
        frame(2040, 1020, 3, 1'b1, 1'b0);
        span(1023, 2030, 2047); span(1023, 0, 8); span(1020, 1, 4);
`ifdef SPRITE_MIRROR_EN
        frame(100, 50, 0, 1'b1, 1'b1);
        span(50, 98, 110); span(57, 98, 110);
`endif
        frame(100, 50, 1, 1'b1, 1'b0);
        span(50, 98, 104);
        pulse_reset();
        span(50, 105, 120);
        frame(100, 50, 1, 1'b1, 1'b0);
        span(51, 98, 120);
        for (int f = 0; f < 6; f++) begin
            load(2);
            x = int'($urandom_range(0, 2047));
            y = int'($urandom_range(0, 1023));
            sc = int'($urandom_range(0, 3));
            ext = W << sc;
            frame(x, y, sc, ($urandom_range(0, 4) != 0), 1'($urandom));
            for (int n = 0; n < 120; n++) begin
                h = (x + int'($urandom_range(0, ext + 8)) - 4) & 2047;
                v = (y + int'($urandom_range(0, ext + 8)) - 4) & 1023;
                cyc(h, v);
            end
        end
        repeat (8) cyc(1, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
